// File: rtl/rf_write_arbiter_if.sv
// Bundle of requester handshakes and the register-file write port.
// The arbiter takes the slave side; the requesters/core take the master side.
interface rf_write_arbiter_if #(
   parameter int NREQ = 2,
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic                 hold;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*XLEN-1:0] req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 WE3;
   logic [AW-1:0]        A3;
   logic [XLEN-1:0]      WD3;
   logic [2**AW-1:0]     busy_mask;

   modport master (
      output hold, req_valid, req_addr, req_data,
      input  req_ready, WE3, A3, WD3, busy_mask
   );

   modport slave (
      input  hold, req_valid, req_addr, req_data,
      output req_ready, WE3, A3, WD3, busy_mask
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NREQ
// writeback requesters, with one registered output stage and a busy scoreboard.
module rf_write_arbiter #(
   parameter int NREQ = 2,
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input logic               clk,
   input logic               reset,
   rf_write_arbiter_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]     r_ptr;
   logic              r_we;
   logic [AW-1:0]     r_a3;
   logic [XLEN-1:0]   r_wd;

   logic              w_found;
   logic [PW-1:0]     w_win;
   logic [NREQ-1:0]   w_grant;
   logic [PW-1:0]     w_ptr_next;
   logic [AW-1:0]     w_addr;
   logic [XLEN-1:0]   w_data;
   logic [2**AW-1:0]  w_busy;

   // Search from the pointer upward with wraparound; the first valid requester wins.
   always_comb begin : pick
      int idx;
      idx     = 0;
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(r_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!w_found && bus.req_valid[idx]) begin
            w_found = 1'b1;
            w_win   = idx[PW-1:0];
         end
      end
      if (bus.hold) w_found = 1'b0;
   end

   always_comb begin
      w_grant    = '0;
      w_ptr_next = r_ptr;
      if (w_found) begin
         w_grant[w_win] = 1'b1;
         w_ptr_next     = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);
      end
   end

   assign w_addr = bus.req_addr[int'(w_win)*AW +: AW];
   assign w_data = bus.req_data[int'(w_win)*XLEN +: XLEN];

   // Output stage never backpressures; x0 writes are accepted but leave WE3 low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr <= '0;
         r_we  <= 1'b0;
         r_a3  <= '0;
         r_wd  <= '0;
      end else if (w_found) begin
         r_ptr <= w_ptr_next;
         r_we  <= (w_addr != '0);
         r_a3  <= w_addr;
         r_wd  <= w_data;
      end else begin
         r_we  <= 1'b0;
      end
   end

   always_comb begin
      w_busy = '0;
      if (r_we) w_busy[r_a3] = 1'b1;
   end

   assign bus.req_ready = w_grant;
   assign bus.WE3       = r_we;
   assign bus.A3        = r_a3;
   assign bus.WD3       = r_wd;
   assign bus.busy_mask = w_busy;
endmodule
